// File: rtl/vc32_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vc32_bus_pkg
//  Description : Definitions shared by both ends of the vc32 byte-serial bus:
//                the responder FSM states, the CMD byte layout and the
//                default frame geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package vc32_bus_pkg;

    localparam int CMD_WR_BIT     = 7;
    localparam int CMD_BE_LSB     = 0;
    localparam int DEF_ADDR_BYTES = 3;
    localparam int DEF_DATA_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_MEM   = 3'd3,
        ST_TURN  = 3'd4,
        ST_RD    = 3'd5,
        ST_DONE  = 3'd6
    } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/vc32_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vc32_bus_responder
//  Description : Target end of the vc32 byte-serial uio bus. Collects a
//                CMD/address/write-data frame, performs one access on a
//                simple memory port and returns read data or an ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc32_bus_responder
    import vc32_bus_pkg::*;
#(
    parameter int ADDR_BYTES = DEF_ADDR_BYTES,
    parameter int DATA_BYTES = DEF_DATA_BYTES,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                bus_in,
    input  logic                      bus_strb,
    output logic [7:0]                bus_out,
    output logic [7:0]                bus_oe,
    output logic                      bus_ack,
    output logic                      bus_err,
    output logic [8*ADDR_BYTES-1:0]   mem_addr,
    output logic [8*DATA_BYTES-1:0]   mem_wdata,
    output logic [DATA_BYTES-1:0]     mem_be,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [8*DATA_BYTES-1:0]   mem_rdata,
    input  logic                      mem_ready
);

    localparam int c_aw        = 8 * ADDR_BYTES;
    localparam int c_dw        = 8 * DATA_BYTES;
    localparam int c_max_bytes = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int c_bcnt_w    = (c_max_bytes > 1) ? $clog2(c_max_bytes) : 1;
    localparam int c_tcnt_w    = $clog2(TIMEOUT + 1);

    localparam logic [c_bcnt_w-1:0] c_addr_last = c_bcnt_w'(ADDR_BYTES - 1);
    localparam logic [c_bcnt_w-1:0] c_data_last = c_bcnt_w'(DATA_BYTES - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one  = c_bcnt_w'(1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TIMEOUT - 1);
    localparam logic [c_tcnt_w-1:0] c_tcnt_max  = c_tcnt_w'(TIMEOUT);
    localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);

    bus_state_e            r_state;
    bus_state_e            w_state_next;
    logic [c_bcnt_w-1:0]   r_bcnt;
    logic [c_tcnt_w-1:0]   r_tcnt;
    logic                  r_is_wr;
    logic                  r_err;
    logic [c_aw-1:0]       r_addr;
    logic [c_dw-1:0]       r_wdata;
    logic [c_dw-1:0]       r_rdata;
    logic [DATA_BYTES-1:0] r_be;
    logic                  w_mem_done;
    logic                  w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_strb) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (!bus_strb) begin
                    w_state_next = ST_IDLE;
                end else if (r_bcnt == c_addr_last) begin
                    w_state_next = r_is_wr ? ST_WDATA : ST_MEM;
                end
            end
            ST_WDATA: begin
                if (!bus_strb) begin
                    w_state_next = ST_IDLE;
                end else if (r_bcnt == c_data_last) begin
                    w_state_next = ST_MEM;
                end
            end
            ST_MEM: begin
                // mem_ready wins over a timeout expiring in the same cycle
                if (mem_ready) begin
                    w_mem_done = 1'b1;
                end else if (r_tcnt == c_tcnt_last) begin
                    w_timeout = 1'b1;
                end
                if (w_mem_done || w_timeout) begin
                    w_state_next = r_is_wr ? ST_DONE : ST_TURN;
                end
            end
            ST_TURN: w_state_next = ST_RD;
            ST_RD: begin
                if (r_bcnt == c_data_last) w_state_next = ST_IDLE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_tcnt  <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= '0;
        end else begin
            if (r_state != ST_MEM) r_tcnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus_strb) begin
                        r_is_wr <= bus_in[CMD_WR_BIT];
                        r_be    <= bus_in[CMD_BE_LSB +: DATA_BYTES];
                        r_bcnt  <= '0;
                    end
                end
                ST_ADDR: begin
                    if (bus_strb) begin
                        r_addr <= (r_addr << 8) | c_aw'(bus_in);
                        r_bcnt <= (r_bcnt == c_addr_last) ? '0 : r_bcnt + c_bcnt_one;
                    end
                end
                ST_WDATA: begin
                    if (bus_strb) begin
                        r_wdata <= (r_wdata >> 8) | (c_dw'(bus_in) << (c_dw - 8));
                        r_bcnt  <= (r_bcnt == c_data_last) ? '0 : r_bcnt + c_bcnt_one;
                    end
                end
                ST_MEM: begin
                    if (w_mem_done || w_timeout) begin
                        r_rdata <= w_timeout ? '1 : mem_rdata;
                        r_err   <= w_timeout;
                        r_bcnt  <= '0;
                    end else if (r_tcnt != c_tcnt_max) begin
                        r_tcnt <= r_tcnt + c_tcnt_one;
                    end
                end
                ST_RD: begin
                    r_rdata <= r_rdata >> 8;
                    r_bcnt  <= (r_bcnt == c_data_last) ? '0 : r_bcnt + c_bcnt_one;
                end
                default: ;
            endcase
        end
    end

    // Bus-side outputs decode straight from state so reset clears them at once
    assign bus_oe    = (r_state == ST_RD) ? 8'hFF : 8'h00;
    assign bus_out   = (r_state == ST_RD) ? r_rdata[7:0] : 8'h00;
    assign bus_ack   = (r_state == ST_RD) || (r_state == ST_DONE);
    assign bus_err   = bus_ack && r_err;
    assign mem_we    = (r_state == ST_MEM) && r_is_wr;
    assign mem_re    = (r_state == ST_MEM) && !r_is_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule
`default_nettype wire
